modport_regfile: RTL and testbench

MODPORT_REGFILE -- requirements
Module: modport_regfile

---
 rtl/modport_regfile.sv | 103 ++++++++++
 tb/tb_modport_regfile.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/modport_regfile.sv
// Register file with a registered two-operand read port and a gated write-back port.
// Reads are write-first: a same-edge write to a matching nonzero rd_q is forwarded to the operands.
module modport_regfile #(
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rs_addr_valid,
  input  logic [ADDR_WIDTH-1:0] rs1_rs2_rd,
  input  logic                  rs_store,
  input  logic [BUS_WIDTH-1:0]  imme_data,
  input  logic                  rd_wr_en,
  input  logic                  op_done,
  input  logic [BUS_WIDTH-1:0]  rs_data_mux,
  output logic [BUS_WIDTH-1:0]  rs_data,
  output logic [BUS_WIDTH-1:0]  alu_data_out,
  output logic                  alu_data_valid
);

  localparam int AW   = ADDR_WIDTH / 3;
  localparam int NREG = 2 ** AW;

  // Handshake: rs_addr_valid has no ready; each edge it is high is one accepted
  // request, and alu_data_valid is high in exactly the following cycle.
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic [AW-1:0] rd_addr;

  assign rs1_addr = rs1_rs2_rd[AW-1:0];
  assign rs2_addr = rs1_rs2_rd[2*AW-1:AW];
  assign rd_addr  = rs1_rs2_rd[3*AW-1:2*AW];

  logic [BUS_WIDTH-1:0] rf_q [NREG];
  logic [AW-1:0]        rd_q;
  logic [BUS_WIDTH-1:0] rs_data_q;
  logic [BUS_WIDTH-1:0] alu_data_q;
  logic                 valid_q;

  logic                 wr_fire;
  logic                 wr_live;
  logic [AW-1:0]        rd_d;
  logic [BUS_WIDTH-1:0] rs1_val;
  logic [BUS_WIDTH-1:0] rs2_val;
  logic [BUS_WIDTH-1:0] rs_data_d;
  logic [BUS_WIDTH-1:0] alu_data_d;

  assign wr_fire = rd_wr_en & op_done;
  // Writes to entry 0 are dropped, so they must not be forwarded either.
  assign wr_live = wr_fire && (rd_q != '0);

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1_addr != '0) begin
      rs1_val = (wr_live && (rd_q == rs1_addr)) ? rs_data_mux : rf_q[rs1_addr];
    end
    if (rs2_addr != '0) begin
      rs2_val = (wr_live && (rd_q == rs2_addr)) ? rs_data_mux : rf_q[rs2_addr];
    end
  end

  always_comb begin
    rd_d       = rd_q;
    rs_data_d  = rs_data_q;
    alu_data_d = alu_data_q;
    if (rs_addr_valid) begin
      rd_d       = rd_addr;
      rs_data_d  = rs1_val;
      alu_data_d = rs_store ? imme_data : rs2_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wr_live) begin
      rf_q[rd_q] <= rs_data_mux;
    end
  end

  // The write above consumes the old rd_q; a coincident request only updates it here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q       <= '0;
      rs_data_q  <= '0;
      alu_data_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      rd_q       <= rd_d;
      rs_data_q  <= rs_data_d;
      alu_data_q <= alu_data_d;
      valid_q    <= rs_addr_valid;
    end
  end

  assign rs_data        = rs_data_q;
  assign alu_data_out   = alu_data_q;
  assign alu_data_valid = valid_q;

endmodule

// File: tb/tb_modport_regfile.sv
// Directed vector bench for modport_regfile: a per-cycle stimulus table plus
// hand-written reset sequences, all expected values computed by hand.
module tb_modport_regfile;

  localparam int BW = 32;
  localparam int AWID = 15;

  logic            clk;
  logic            rst_n;
  logic            rs_addr_valid;
  logic [AWID-1:0] rs1_rs2_rd;
  logic            rs_store;
  logic [BW-1:0]   imme_data;
  logic            rd_wr_en;
  logic            op_done;
  logic [BW-1:0]   rs_data_mux;
  logic [BW-1:0]   rs_data;
  logic [BW-1:0]   alu_data_out;
  logic            alu_data_valid;

  int checks;
  int failures;

  modport_regfile #(.BUS_WIDTH(BW), .ADDR_WIDTH(AWID)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rs_addr_valid (rs_addr_valid),
    .rs1_rs2_rd    (rs1_rs2_rd),
    .rs_store      (rs_store),
    .imme_data     (imme_data),
    .rd_wr_en      (rd_wr_en),
    .op_done       (op_done),
    .rs_data_mux   (rs_data_mux),
    .rs_data       (rs_data),
    .alu_data_out  (alu_data_out),
    .alu_data_valid(alu_data_valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          req;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [4:0]    rd;
    logic          store;
    logic [BW-1:0] imme;
    logic          wr_en;
    logic          done;
    logic [BW-1:0] mux;
    logic [BW-1:0] exp_rs;
    logic [BW-1:0] exp_alu;
    logic          exp_valid;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic req, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic store, logic [BW-1:0] imme, logic wr_en, logic done,
                              logic [BW-1:0] mux, logic [BW-1:0] exp_rs,
                              logic [BW-1:0] exp_alu, logic exp_valid);
    vec_t v;
    v.req = req; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.store = store; v.imme = imme;
    v.wr_en = wr_en; v.done = done; v.mux = mux;
    v.exp_rs = exp_rs; v.exp_alu = exp_alu; v.exp_valid = exp_valid;
    return v;
  endfunction

  task automatic check(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_outs(string tag, logic [BW-1:0] e_rs, logic [BW-1:0] e_alu, logic e_v);
    check({tag, ".rs_data"}, rs_data, e_rs);
    check({tag, ".alu_data_out"}, alu_data_out, e_alu);
    check({tag, ".alu_data_valid"}, {31'd0, alu_data_valid}, {31'd0, e_v});
  endtask

  // driver
  task automatic drive(vec_t v);
    rs_addr_valid = v.req;
    rs1_rs2_rd    = {v.rd, v.rs2, v.rs1};
    rs_store      = v.store;
    imme_data     = v.imme;
    rd_wr_en      = v.wr_en;
    op_done       = v.done;
    rs_data_mux   = v.mux;
  endtask

  task automatic idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    idle();

    // Each row is one clock: drive, edge, compare 1ns later.
    vecs.push_back(mk(1, 0, 0, 5, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF, 32'h0, 32'h0, 0));
    vecs.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0, 0));
    vecs.push_back(mk(1, 5, 5, 7, 1, 32'h123, 0, 0, 0, 32'hDEADBEEF, 32'h123, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 32'h11111111, 32'hDEADBEEF, 32'h123, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h22222222, 32'hDEADBEEF, 32'h123, 0));
    vecs.push_back(mk(1, 7, 5, 0, 0, 0, 0, 0, 0, 32'h0, 32'hDEADBEEF, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'hFFFFFFFF, 32'h0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 0, 0, 3, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1));
    vecs.push_back(mk(1, 3, 3, 3, 0, 0, 1, 1, 32'h0000AAAA, 32'h0000AAAA, 32'h0000AAAA, 1));
    vecs.push_back(mk(1, 3, 0, 9, 0, 0, 0, 0, 0, 32'h0000AAAA, 32'h0, 1));
    vecs.push_back(mk(1, 9, 3, 4, 0, 0, 1, 1, 32'h12345678, 32'h12345678, 32'h0000AAAA, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h55555555, 32'h12345678, 32'h0000AAAA, 0));
    vecs.push_back(mk(1, 4, 9, 0, 0, 0, 0, 0, 0, 32'h55555555, 32'h12345678, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 32'h0000CAFE, 32'h0, 32'h0, 1));
    vecs.push_back(mk(1, 31, 0, 0, 1, 32'hFFFFFFFF, 0, 0, 0, 32'h0, 32'hFFFFFFFF, 1));

    #12;
    check_outs("reset_hold", 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].exp_rs, vecs[i].exp_alu, vecs[i].exp_valid);
      idle();
    end

    // Request in flight, then reset mid-cycle with a write strobe held.
    drive(mk(1, 5, 9, 6, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check_outs("pre_reset", 32'hDEADBEEF, 32'h12345678, 1'b1);
    drive(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h77777777, 0, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_reset", 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check_outs("reset_edge", 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after release is a normal operating edge; memory is cleared.
    drive(mk(1, 5, 9, 6, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check_outs("post_reset_a", 32'h0, 32'h0, 1'b1);
    drive(mk(1, 4, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check_outs("post_reset_b", 32'h0, 32'h0, 1'b1);
    idle();
    @(posedge clk);
    #1;
    check_outs("post_reset_idle", 32'h0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
